// File: rtl/demux_strobe_arb.sv
// Round-robin arbiter and setup/strobe/hold sequencer driving a 74x138-style decoder.
// Define DEMUX_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead of round-robin.
module demux_strobe_arb #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [7:0] ack,
  output logic       busy,
  output logic [2:0] sel_a,
  output logic       sel_g1,
  output logic       sel_g2a,
  output logic       sel_g2b
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [7:0] ack_q, ack_d;
  logic       busy_q, busy_d;
  logic [2:0] sel_a_q, sel_a_d;
  logic       g1_q, g1_d;
  logic       g2_q, g2_d;

  logic [2:0] win;
  logic       found;

`ifndef DEMUX_ARB_FIXED_PRI_EN
  logic [2:0] p_q, p_d;
  logic [2:0] idx;
`endif

  // Winner selection: search starts at the priority pointer (or at 0 in fixed mode).
  always_comb begin
    win   = '0;
    found = 1'b0;
`ifdef DEMUX_ARB_FIXED_PRI_EN
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && req[i]) begin
        win   = 3'(i);
        found = 1'b1;
      end
    end
`else
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = p_q + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`endif
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      sel_a_q <= '0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b1;
`ifndef DEMUX_ARB_FIXED_PRI_EN
      p_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      sel_a_q <= sel_a_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
`ifndef DEMUX_ARB_FIXED_PRI_EN
      p_q     <= p_d;
`endif
    end
  end

  // Next-state and phase counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the upcoming state so they register in step with it;
  // ack fires when the next cycle is the final HOLD cycle.
  always_comb begin
    grant_d = grant_q;
    busy_d  = busy_q;
    sel_a_d = sel_a_q;
`ifndef DEMUX_ARB_FIXED_PRI_EN
    p_d     = p_q;
`endif
    if (state_q == IDLE && state_d == SETUP) begin
      grant_d = 8'b1 << win;
      busy_d  = 1'b1;
      sel_a_d = win;
`ifndef DEMUX_ARB_FIXED_PRI_EN
      p_d     = win + 3'd1;
`endif
    end else if (state_q == HOLD && state_d == IDLE) begin
      grant_d = '0;
      busy_d  = 1'b0;
    end
    g1_d  = (state_d == STROBE);
    g2_d  = ~g1_d;
    ack_d = (state_d == HOLD && cnt_d == '0) ? grant_d : '0;
  end

  assign grant   = grant_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign sel_a   = sel_a_q;
  assign sel_g1  = g1_q;
  assign sel_g2a = g2_q;
  assign sel_g2b = g2_q;

endmodule

// File: tb/tb_demux_strobe_arb.sv
// Self-checking bench for demux_strobe_arb: transaction-level reference model plus scenario tasks.
// Define DEMUX_ARB_FIXED_PRI_EN for both RTL and bench to exercise fixed priority.
module tb_demux_strobe_arb;

  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 1;
  localparam int L = S + T + H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'hFF;
  logic [7:0] grant, ack;
  logic       busy;
  logic [2:0] sel_a;
  logic       sel_g1, sel_g2a, sel_g2b;

  int checks = 0;
  int errors = 0;

  demux_strobe_arb #(
    .SETUP_CYC (S),
    .STROBE_CYC(T),
    .HOLD_CYC  (H)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .grant  (grant),
    .ack    (ack),
    .busy   (busy),
    .sel_a  (sel_a),
    .sel_g1 (sel_g1),
    .sel_g2a(sel_g2a),
    .sel_g2b(sel_g2b)
  );

  always #5 clk = ~clk;

  // Reference model: a transaction is an owner plus elapsed cycles since its grant.
  bit m_busy = 0;
  int m_owner = 0;
  int m_t = 0;
  int m_p = 0;
  int m_sel = 0;

  function automatic int pick(input logic [7:0] r, input int p);
    int start;
`ifdef DEMUX_ARB_FIXED_PRI_EN
    start = 0;
`else
    start = p;
`endif
    for (int i = 0; i < 8; i++)
      if (r[(start + i) % 8]) return (start + i) % 8;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_p = 0; m_sel = 0; m_t = 0;
    end else if (!m_busy) begin
      if (req != 8'h00) begin
        m_owner = pick(req, m_p);
        m_busy  = 1;
        m_t     = 0;
        m_sel   = m_owner;
        m_p     = (m_owner + 1) % 8;
      end
    end else begin
      m_t = m_t + 1;
      if (m_t == L) m_busy = 0;
    end
  end

  // Expected {grant, ack, busy, sel_a, g1, g2a, g2b}.
  function automatic logic [22:0] exp_vec();
    logic [7:0] g, a;
    logic       en;
    g  = m_busy ? (8'd1 << m_owner) : 8'd0;
    a  = (m_busy && m_t == L - 1) ? g : 8'd0;
    en = m_busy && (m_t >= S) && (m_t < S + T);
    return {g, a, m_busy, 3'(m_sel), en, ~en, ~en};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {grant, ack, busy, sel_a, sel_g1, sel_g2a, sel_g2b};
  endfunction

  function automatic int oh2idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== {8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL reset cyc %0d: got %h, required %h", c, obs_vec(),
                 {8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1});
      end
    end
  endtask

  task automatic test_single();
    logic [22:0] e;
    reset = 1'b0; req = 8'h20;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      req = 8'h00;
      case (c)
        1:       e = {8'h20, 8'h00, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1};
        2, 3:    e = {8'h20, 8'h00, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
        4:       e = {8'h20, 8'h20, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1};
        default: e = {8'h00, 8'h00, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1};
      endcase
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL single cyc %0d: got %h, required %h", c, obs_vec(), e);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_model cyc %0d: got %h, required %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_all_requesting();
    int starts[$];
    int stamps[$];
    int acks = 0;
    logic [7:0] prev_g = 8'h00;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req = 8'hFF;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL all_model cyc %0d: got %h, required %h", c, obs_vec(), exp_vec());
      end
      if (prev_g == 8'h00 && grant != 8'h00) begin
        starts.push_back(oh2idx(grant));
        stamps.push_back(c);
      end
      if (ack != 8'h00) begin
        acks++;
        checks++;
        if (ack !== grant) begin
          errors++;
          $display("FAIL all_ack_owner cyc %0d: ack %h, required %h", c, ack, grant);
        end
      end
      prev_g = grant;
    end
    checks++;
    if (starts.size() != 9) begin
      errors++;
      $display("FAIL all_grant_count: got %0d, required 9", starts.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (starts[i] != i % 8 || stamps[i] != 1 + 5 * i) begin
          errors++;
          $display("FAIL all_order #%0d: owner %0d at %0d, required %0d at %0d",
                   i, starts[i], stamps[i], i % 8, 1 + 5 * i);
        end
      end
    end
    checks++;
    if (acks != 9) begin
      errors++;
      $display("FAIL all_ack_count: got %0d, required 9", acks);
    end
  endtask

  task automatic test_wrap();
    int starts[$];
    int cyc = 0;
    logic [7:0] prev_g;
    int want[3] = '{0, 6, 0};
    req = 8'hFF;
    prev_g = grant;
    while (!(prev_g == 8'h00 && grant == 8'h40) && cyc < 100) begin
      prev_g = grant;
      @(posedge clk); #1;
      cyc++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_model: got %h, required %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (grant !== 8'h40) begin
      errors++;
      $display("FAIL wrap_reach6: timeout, grant %h, required 40", grant);
    end
    req = 8'h41;
    prev_g = grant;
    for (int c = 0; c < 40 && starts.size() < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_model2: got %h, required %h", obs_vec(), exp_vec());
      end
      if (prev_g == 8'h00 && grant != 8'h00) starts.push_back(oh2idx(grant));
      prev_g = grant;
    end
    checks++;
    if (starts.size() != 3) begin
      errors++;
      $display("FAIL wrap_count: got %0d grants, required 3", starts.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (starts[i] != want[i]) begin
          errors++;
          $display("FAIL wrap_order #%0d: got %0d, required %0d", i, starts[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_strobe();
    int cyc = 0;
    req = 8'h48;
    while (sel_g1 !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (sel_g1 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_strobe: timeout waiting for strobe");
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sel_g1, sel_g2a, sel_g2b, ack, grant, busy} !== {3'b011, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midrst_outputs: got %b/%h/%h/%b, required 011/00/00/0",
               {sel_g1, sel_g2a, sel_g2b}, ack, grant, busy);
    end
    reset = 1'b0; req = 8'hFF;
    @(posedge clk); #1;
    checks++;
    if (grant !== 8'h01 || sel_a !== 3'd0) begin
      errors++;
      $display("FAIL midrst_restart: grant %h sel %0d, required 01 sel 0", grant, sel_a);
    end
    req = 8'h00;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midrst_model cyc %0d: got %h, required %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      req   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = 8'h00;
      reset = ($urandom_range(0, 60) == 0);
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h, required %h", c, obs_vec(), exp_vec());
      end
      if (ack != 8'h00) begin
        checks++;
        if (sel_g1 !== 1'b0 || ack !== grant) begin
          errors++;
          $display("FAIL random_ack cyc %0d: ack %h grant %h g1 %b", c, ack, grant, sel_g1);
        end
      end
    end
    reset = 1'b0;
  endtask

`ifdef DEMUX_ARB_FIXED_PRI_EN
  task automatic test_fixed_priority();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req = 8'h81;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      checks++;
      if (grant !== 8'h00 && grant !== 8'h01) begin
        errors++;
        $display("FAIL fixed cyc %0d: grant %h, required 01 or 00", c, grant);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fixed_model cyc %0d: got %h, required %h", c, obs_vec(), exp_vec());
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_requesting();
    test_wrap();
    test_reset_mid_strobe();
`ifdef DEMUX_ARB_FIXED_PRI_EN
    test_fixed_priority();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
